// File: rtl/pdma_fifo_ctrl.sv
// PDMA FIFO controller: 16-bit word writes into a dual-port micro-RAM, 8-bit byte stream out
// through read port A with a one-cycle RAM latency stage and a 2-entry output buffer.
module pdma_fifo_ctrl #(
  parameter int unsigned WR_AW = 7,
  parameter int unsigned RD_AW = WR_AW + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             WE,
  input  logic [15:0]      WDATA,
  output logic             FULL,
  output logic             WR_ERR,
  output logic             RD_VALID,
  output logic [7:0]       RD_DATA,
  input  logic             RD_READY,
  output logic             EMPTY,
  output logic [RD_AW:0]   BYTE_CNT,
  output logic             C_WEN,
  output logic [WR_AW-1:0] C_ADDR,
  output logic [15:0]      C_DIN,
  output logic             C_BLK,
  output logic [RD_AW-1:0] A_ADDR,
  output logic             A_ADDR_EN,
  output logic             A_BLK,
  input  logic [7:0]       A_DOUT
);

  localparam int unsigned CntW = RD_AW + 1;
  localparam logic [CntW-1:0] Cap = CntW'(1) << RD_AW;

  logic [WR_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  byte_cnt_q, byte_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic             ob_head_q, ob_head_d;
  logic [7:0]       ob_mem_q [2];
  logic             wr_err_q, wr_err_d;

  logic       full;
  logic       rd_valid;
  logic       pop;
  logic       wr_acc;
  logic       fetch;
  logic [2:0] ob_level;
  logic       ob_tail;

  assign full     = byte_cnt_q > (Cap - CntW'(2));
  assign rd_valid = ob_cnt_q != 2'd0;
  assign pop      = rd_valid & RD_READY;
  assign wr_acc   = WE & ~full & ~FLUSH;
  // Buffer occupancy after this edge, counting the byte already in flight from the RAM.
  assign ob_level = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fetch    = (byte_cnt_q != '0) & (ob_level < 3'd2) & ~FLUSH;
  // With a byte in flight ob_cnt_q is at most 1, so the tail is head or head^1.
  assign ob_tail  = ob_head_q ^ ob_cnt_q[0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + WR_AW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + RD_AW'(fetch);
    byte_cnt_d = byte_cnt_q + (wr_acc ? CntW'(2) : '0) - CntW'(fetch);
    inflight_d = fetch;
    ob_cnt_d   = ob_level[1:0];
    ob_head_d  = ob_head_q ^ pop;
    wr_err_d   = WE & full & ~FLUSH;
    if (FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_cnt_d = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = 2'd0;
      ob_head_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      ob_cnt_q    <= 2'd0;
      ob_head_q   <= 1'b0;
      ob_mem_q[0] <= 8'h00;
      ob_mem_q[1] <= 8'h00;
      wr_err_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob_head_q  <= ob_head_d;
      wr_err_q   <= wr_err_d;
      if (inflight_q && !FLUSH) begin
        ob_mem_q[ob_tail] <= A_DOUT;
      end
    end
  end

  assign FULL      = full;
  assign WR_ERR    = wr_err_q;
  assign RD_VALID  = rd_valid;
  assign RD_DATA   = ob_mem_q[ob_head_q];
  assign EMPTY     = (byte_cnt_q == '0) & ~inflight_q & (ob_cnt_q == 2'd0);
  assign BYTE_CNT  = byte_cnt_q;
  // Gate with RESET so the write strobe drops the moment reset asserts.
  assign C_WEN     = wr_acc & ~RESET;
  assign C_ADDR    = wr_ptr_q;
  assign C_DIN     = WDATA;
  assign C_BLK     = 1'b1;
  assign A_ADDR    = rd_ptr_q;
  assign A_ADDR_EN = fetch;
  assign A_BLK     = 1'b1;

endmodule

// File: tb/tb_pdma_fifo_ctrl.sv
// Bench for pdma_fifo_ctrl: behavioural RAM model, cycle vector table, and directed
// fill/stream/flush/reset sequences with a byte scoreboard.
module tb_pdma_fifo_ctrl;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        WE;
  logic [15:0] WDATA;
  logic        FULL;
  logic        WR_ERR;
  logic        RD_VALID;
  logic [7:0]  RD_DATA;
  logic        RD_READY;
  logic        EMPTY;
  logic [8:0]  BYTE_CNT;
  logic        C_WEN;
  logic [6:0]  C_ADDR;
  logic [15:0] C_DIN;
  logic        C_BLK;
  logic [7:0]  A_ADDR;
  logic        A_ADDR_EN;
  logic        A_BLK;
  logic [7:0]  A_DOUT;

  pdma_fifo_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .WE        (WE),
    .WDATA     (WDATA),
    .FULL      (FULL),
    .WR_ERR    (WR_ERR),
    .RD_VALID  (RD_VALID),
    .RD_DATA   (RD_DATA),
    .RD_READY  (RD_READY),
    .EMPTY     (EMPTY),
    .BYTE_CNT  (BYTE_CNT),
    .C_WEN     (C_WEN),
    .C_ADDR    (C_ADDR),
    .C_DIN     (C_DIN),
    .C_BLK     (C_BLK),
    .A_ADDR    (A_ADDR),
    .A_ADDR_EN (A_ADDR_EN),
    .A_BLK     (A_BLK),
    .A_DOUT    (A_DOUT)
  );

  // RAM: registered read address, data visible the cycle after the fetch edge.
  logic [15:0] mem [128];
  logic [7:0]  a_addr_q;
  always @(posedge CLK) begin
    if (C_WEN) mem[C_ADDR] <= C_DIN;
    if (A_ADDR_EN) a_addr_q <= A_ADDR;
  end
  assign A_DOUT = a_addr_q[0] ? mem[a_addr_q[7:1]][15:8] : mem[a_addr_q[7:1]][7:0];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] wdata;
    logic        rdy;
    logic        flush;
    logic        valid;
    logic [7:0]  data;
    logic        empty;
    logic        full;
    logic [8:0]  cnt;
    logic        cwen;
    logic        fetch;
  } vec_t;

  function automatic vec_t mk(logic we, logic [15:0] wd, logic rdy, logic fl, logic v,
                              logic [7:0] d, logic e, logic f, logic [8:0] c, logic cw,
                              logic fe);
    vec_t r;
    r.we = we; r.wdata = wd; r.rdy = rdy; r.flush = fl; r.valid = v; r.data = d;
    r.empty = e; r.full = f; r.cnt = c; r.cwen = cw; r.fetch = fe;
    return r;
  endfunction

  // Scoreboard for the streaming phase.
  logic [7:0] exp_q [$];
  logic       mon_en = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data;
  int         mon_bytes = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_hold", {RD_VALID, RD_DATA}, {1'b1, held_data});
      end
      check("ob_cnt_le2", 32'(dut.ob_cnt_q <= 2'd2), 32'd1);
      if (RD_VALID && RD_READY) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_byte", {1'b1, RD_DATA}, 32'd0);
        end else begin
          check("stream_byte", RD_DATA, exp_q.pop_front());
        end
        mon_bytes++;
      end
      stall_prev = RD_VALID & ~RD_READY;
      held_data  = RD_DATA;
    end else begin
      stall_prev = 1'b0;
    end
  end

  vec_t vecs [$];
  logic [21:0] act_v, exp_v;
  logic [7:0]  got [$];
  int          wn;
  int          sent;
  int          budget;

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; WE = 1'b0; WDATA = '0; RD_READY = 1'b0;

    //           we  wdata    rdy fl | v  data  e  f  cnt  cwen fetch
    vecs.push_back(mk(1, 16'hBEEF, 1, 0, 0, 8'h00, 1, 0, 9'd0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 8'h00, 0, 0, 9'd2, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 8'h00, 0, 0, 9'd1, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'hEF, 0, 0, 9'd0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'hBE, 0, 0, 9'd0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 8'h00, 1, 0, 9'd0, 0, 0));
    vecs.push_back(mk(1, 16'h1234, 0, 0, 0, 8'h00, 1, 0, 9'd0, 1, 0));
    vecs.push_back(mk(1, 16'h5678, 0, 0, 0, 8'h00, 0, 0, 9'd2, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 9'd3, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 8'h34, 0, 0, 9'd2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 8'h34, 0, 0, 9'd2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'h34, 0, 0, 9'd2, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'h12, 0, 0, 9'd1, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'h78, 0, 0, 9'd0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 8'h56, 0, 0, 9'd0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 8'h00, 1, 0, 9'd0, 0, 0));
    vecs.push_back(mk(1, 16'hAAAA, 0, 0, 0, 8'h00, 1, 0, 9'd0, 1, 0));
    vecs.push_back(mk(1, 16'hBBBB, 0, 1, 0, 8'h00, 0, 0, 9'd2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 8'h00, 1, 0, 9'd0, 0, 0));

    // Reset state
    tick(); tick();
    check("reset_outs", {FULL, WR_ERR, RD_VALID, RD_DATA, EMPTY, BYTE_CNT, C_WEN, A_ADDR_EN},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0});
    check("blk_tied", {C_BLK, A_BLK}, 2'b11);
    RESET = 1'b0;
    tick();

    // Cycle table
    foreach (vecs[i]) begin
      WE = vecs[i].we; WDATA = vecs[i].wdata; RD_READY = vecs[i].rdy; FLUSH = vecs[i].flush;
      #3;
      act_v = {RD_VALID, RD_VALID ? RD_DATA : 8'h00, EMPTY, FULL, BYTE_CNT, C_WEN, A_ADDR_EN};
      exp_v = {vecs[i].valid, vecs[i].valid ? vecs[i].data : 8'h00, vecs[i].empty,
               vecs[i].full, vecs[i].cnt, vecs[i].cwen, vecs[i].fetch};
      check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
      tick();
    end
    WE = 1'b0; FLUSH = 1'b0; RD_READY = 1'b0;
    tick();

    // Fill: 129 words land (two bytes pre-fetched), then one more is dropped
    for (int k = 0; k < 129; k++) begin
      if (k == 128) begin
        #1;
        check("fill_cnt254", {FULL, BYTE_CNT}, {1'b0, 9'd254});
      end
      WE = 1'b1; WDATA = {8'(2 * k + 1), 8'(2 * k)};
      tick();
    end
    WDATA = 16'hDEAD;
    #1;
    check("fill_full", {FULL, BYTE_CNT, C_WEN}, {1'b1, 9'd256, 1'b0});
    check("fill_no_err_yet", WR_ERR, 1'b0);
    tick();
    WE = 1'b0;
    #1;
    check("wr_err_pulse", WR_ERR, 1'b1);
    check("full_cnt_held", BYTE_CNT, 9'd256);
    tick();
    check("wr_err_clear", WR_ERR, 1'b0);
    RD_READY = 1'b1;
    got.delete();
    budget = 0;
    while (got.size() < 258 && budget < 600) begin
      #1;
      if (RD_VALID) got.push_back(RD_DATA);
      tick();
      budget++;
    end
    check("fill_drain_count", got.size(), 258);
    foreach (got[i]) begin
      if (got[i] !== 8'(i)) check($sformatf("fill_byte%0d", i), got[i], 8'(i));
    end
    checks++;
    #1;
    check("fill_empty", {EMPTY, RD_VALID}, 2'b10);

    // Streaming: phase 0 with RD_READY high, phase 1 with random backpressure
    mon_en = 1'b1;
    wn = 0;
    for (int ph = 0; ph < 2; ph++) begin
      sent = 0;
      while (sent < 200) begin
        RD_READY = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1 && !FULL) begin
          WE = 1'b1;
          WDATA = 16'hA000 + 16'(wn);
          exp_q.push_back(WDATA[7:0]);
          exp_q.push_back(WDATA[15:8]);
          wn++;
          sent++;
        end else begin
          WE = 1'b0;
        end
        tick();
      end
    end
    WE = 1'b0;
    budget = 0;
    while (budget < 3000 && !(exp_q.size() == 0 && EMPTY)) begin
      RD_READY = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    RD_READY = 1'b1;
    tick();
    mon_en = 1'b0;
    check("stream_left", exp_q.size(), 0);
    check("stream_bytes", mon_bytes, 800);

    // Flush with BYTE_CNT=40 and a byte in flight
    RD_READY = 1'b0;
    for (int k = 0; k < 22; k++) begin
      WE = 1'b1; WDATA = 16'h5500 + 16'(k);
      tick();
    end
    WE = 1'b0;
    tick(); tick(); tick();
    check("pre_flush_cnt", BYTE_CNT, 9'd42);
    RD_READY = 1'b1;
    tick(); tick();
    RD_READY = 1'b0;
    #1;
    check("flush_setup", {BYTE_CNT, 1'(dut.inflight_q)}, {9'd40, 1'b1});
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_result", {EMPTY, RD_VALID, BYTE_CNT}, {1'b1, 1'b0, 9'd0});
    WE = 1'b1; WDATA = 16'h1234; RD_READY = 1'b1;
    tick();
    WE = 1'b0;
    got.delete();
    budget = 0;
    while (got.size() < 2 && budget < 20) begin
      #1;
      if (RD_VALID) got.push_back(RD_DATA);
      tick();
      budget++;
    end
    check("flush_rd_count", got.size(), 2);
    if (got.size() == 2) begin
      check("flush_rd_bytes", {got[0], got[1]}, 16'h3412);
    end
    tick();
    check("flush_final_empty", EMPTY, 1'b1);

    // Asynchronous reset mid-stream
    RD_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      WE = 1'b1; WDATA = 16'h7700 + 16'(k);
      tick();
    end
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", {FULL, WR_ERR, RD_VALID, RD_DATA, EMPTY, BYTE_CNT, C_WEN, A_ADDR_EN},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0});
    WE = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    check("post_reset", {EMPTY, BYTE_CNT}, {1'b1, 9'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
